// File: rtl/cd101_pkg.sv
// Shared definitions for the cd101 pad-bus arbiter: FSM state encoding and
// default sizing of the requester array.
package cd101_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TURN = 2'd1,
        ST_OWN  = 2'd2
    } state_t;

    localparam int N_REQ_DEF = 4;
    localparam int LEN_W_DEF = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first set request strictly after ptr_i
// (wrapping), so the previous owner ranks last.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] win_oh_o,
    output logic [IDX_W-1:0] win_idx_o,
    output logic             any_o
);

    always_comb begin
        int w_k;
        // NOTE: every output gets a default before the loop so no path leaves
        // a value unassigned, which would otherwise infer a latch.
        w_k       = 0;
        win_oh_o  = '0;
        win_idx_o = '0;
        any_o     = 1'b0;
        // Walk from farthest to nearest; the nearest hit overwrites and wins.
        for (int i = N_REQ; i >= 1; i--) begin
            w_k = int'(ptr_i) + i;
            if (w_k >= N_REQ) w_k = w_k - N_REQ;
            if (req_i[w_k]) begin
                win_oh_o      = '0;
                win_oh_o[w_k] = 1'b1;
                win_idx_o     = IDX_W'(w_k);
                any_o         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uio_bus_arbiter.sv
// Shares the bidirectional uio pad bus between N_REQ requesters in round-robin
// bursts, with a high-Z turnaround cycle whenever ownership changes.
module uio_bus_arbiter
    import cd101_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_i,
    input  logic [N_REQ*LEN_W-1:0] len_i,
    input  logic [N_REQ*8-1:0]     dout_i,
    input  logic [N_REQ*8-1:0]     oe_i,
    output logic [N_REQ-1:0]       gnt_o,
    output logic                   last_o,
    output logic                   busy_o,
    output logic [7:0]             din_o,
    input  logic [7:0]             uio_in,
    output logic [7:0]             uio_out,
    output logic [7:0]             uio_oe
);

    localparam int IDX_W = $clog2(N_REQ);

    state_t           r_state;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_own;
    logic [LEN_W-1:0] r_cnt;
    logic             r_prev_own;

    logic [N_REQ-1:0] w_win_oh;
    logic [IDX_W-1:0] w_win_idx;
    logic             w_any;
    logic [LEN_W-1:0] w_win_len;
    logic             w_own_req;
    logic             w_beat;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i     (req_i),
        .ptr_i     (r_ptr),
        .win_oh_o  (w_win_oh),
        .win_idx_o (w_win_idx),
        .any_o     (w_any)
    );

    always_comb begin
        w_win_len = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_win_oh[k]) w_win_len = len_i[k*LEN_W +: LEN_W];
        end
    end

    // A beat needs the owner still requesting; a dropped request aborts the
    // burst in the same cycle, so grant must follow req_i combinationally.
    assign w_own_req = req_i[r_own];
    assign w_beat    = (r_state == ST_OWN) && w_own_req;
    assign busy_o    = (r_state != ST_IDLE);
    assign last_o    = w_beat && (r_cnt == '0);

    always_comb begin
        gnt_o = '0;
        if (w_beat) gnt_o[r_own] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ptr      <= IDX_W'(N_REQ - 1);
            r_own      <= '0;
            r_cnt      <= '0;
            r_prev_own <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // branch below sees the values from before this edge.
            r_prev_own <= (r_state == ST_OWN);
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_own   <= w_win_idx;
                        r_cnt   <= w_win_len;
                        r_state <= (w_win_idx == r_ptr && r_prev_own) ? ST_OWN : ST_TURN;
                    end
                end
                ST_TURN: r_state <= ST_OWN;
                ST_OWN: begin
                    if (!w_own_req || r_cnt == '0) begin
                        r_ptr   <= r_own;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            uio_out <= '0;
            uio_oe  <= '0;
            din_o   <= '0;
        end else begin
            din_o <= uio_in;
            if (w_beat) begin
                uio_out <= dout_i[int'(r_own)*8 +: 8];
                uio_oe  <= oe_i[int'(r_own)*8 +: 8];
            end else begin
                uio_oe  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Directed bench for uio_bus_arbiter: reset, single burst, same-owner repeat,
// abort, mid-burst reset and round-robin fairness with hand-derived values.
module tb_uio_bus_arbiter;

    localparam int N  = 4;
    localparam int LW = 4;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*LW-1:0] len;
    logic [N*8-1:0]  dout;
    logic [N*8-1:0]  oe;
    logic [N-1:0]    gnt;
    logic            last;
    logic            busy;
    logic [7:0]      din;
    logic [7:0]      uio_in;
    logic [7:0]      uio_out;
    logic [7:0]      uio_oe;

    int vectors    = 0;
    int miscompares = 0;

    uio_bus_arbiter #(.N_REQ(N), .LEN_W(LW)) dut (
        .clk     (clk),
        .rst     (rst),
        .req_i   (req),
        .len_i   (len),
        .dout_i  (dout),
        .oe_i    (oe),
        .gnt_o   (gnt),
        .last_o  (last),
        .busy_o  (busy),
        .din_o   (din),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int k, input logic [LW-1:0] l, input logic [7:0] d, input logic [7:0] o);
        len[k*LW +: LW] = l;
        dout[k*8 +: 8]  = d;
        oe[k*8 +: 8]    = o;
    endtask

    task automatic set_dout(input int k, input logic [7:0] d);
        dout[k*8 +: 8] = d;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; req = '0; len = '0; dout = '0; oe = '0; uio_in = '0;
        #2;
        check("rst_gnt", gnt, 0);
        check("rst_last", last, 0);
        check("rst_busy", busy, 0);
        check("rst_oe", uio_oe, 0);
        check("rst_out", uio_out, 0);
        check("rst_din", din, 0);
        tick(); tick();
        rst = 1'b0;

        // Single burst on requester 2, len 3
        set_lane(2, 4'd3, 8'h11, 8'hFF); req = 4'b0100; uio_in = 8'hA5; #1;
        check("s_idle_gnt", gnt, 0);
        check("s_idle_busy", busy, 0);
        tick(); uio_in = 8'h3C; #1;
        check("s_turn_din", din, 8'hA5);
        check("s_turn_gnt", gnt, 0);
        check("s_turn_busy", busy, 1);
        check("s_turn_oe", uio_oe, 0);
        tick(); #1;
        check("s_b1_din", din, 8'h3C);
        check("s_b1_gnt", gnt, 4'b0100);
        check("s_b1_last", last, 0);
        check("s_b1_oe", uio_oe, 0);
        tick(); set_dout(2, 8'h22); #1;
        check("s_b2_gnt", gnt, 4'b0100);
        check("s_b2_out", uio_out, 8'h11);
        check("s_b2_oe", uio_oe, 8'hFF);
        tick(); set_dout(2, 8'h33); #1;
        check("s_b3_out", uio_out, 8'h22);
        check("s_b3_last", last, 0);
        tick(); set_dout(2, 8'h44); #1;
        check("s_b4_gnt", gnt, 4'b0100);
        check("s_b4_last", last, 1);
        check("s_b4_out", uio_out, 8'h33);
        tick(); req = '0; #1;
        check("s_end_out", uio_out, 8'h44);
        check("s_end_oe", uio_oe, 8'hFF);
        check("s_end_gnt", gnt, 0);
        check("s_end_busy", busy, 0);
        tick();
        set_lane(1, 4'd1, 8'h5A, 8'h0F); req = 4'b0010; #1;
        check("s_hiz_oe", uio_oe, 0);
        check("s_hold_out", uio_out, 8'h44);

        // Same-owner repeat on requester 1, len 1
        tick(); #1;
        check("r_turn_gnt", gnt, 0);
        check("r_turn_busy", busy, 1);
        tick(); #1;
        check("r_a1_gnt", gnt, 4'b0010);
        check("r_a1_last", last, 0);
        tick(); #1;
        check("r_a2_last", last, 1);
        check("r_a2_out", uio_out, 8'h5A);
        check("r_a2_oe", uio_oe, 8'h0F);
        tick(); #1;
        check("r_idle_gnt", gnt, 0);
        check("r_idle_busy", busy, 0);
        check("r_idle_oe", uio_oe, 8'h0F);
        tick(); #1;
        check("r_b1_gnt", gnt, 4'b0010);
        check("r_b1_busy", busy, 1);
        check("r_b1_last", last, 0);
        tick(); #1;
        check("r_b2_last", last, 1);
        tick(); req = '0; #1;
        check("r_end_busy", busy, 0);

        // Abort of requester 3 after two of eight beats
        tick(); set_lane(3, 4'd7, 8'h77, 8'hF0); req = 4'b1000; #1;
        check("a_idle_oe", uio_oe, 0);
        tick(); #1;
        check("a_turn_gnt", gnt, 0);
        tick(); #1;
        check("a_b1_gnt", gnt, 4'b1000);
        tick(); #1;
        check("a_b2_gnt", gnt, 4'b1000);
        check("a_b2_out", uio_out, 8'h77);
        check("a_b2_oe", uio_oe, 8'hF0);
        tick(); req = '0; #1;
        check("a_drop_gnt", gnt, 0);
        check("a_drop_busy", busy, 1);
        check("a_drop_last", last, 0);
        check("a_drop_oe", uio_oe, 8'hF0);
        tick(); set_lane(0, 4'd0, 8'hC3, 8'hAA); req = 4'b1001; #1;
        check("a_idle2_busy", busy, 0);
        check("a_idle2_oe", uio_oe, 0);
        tick(); #1;
        check("a_turn2_gnt", gnt, 0);
        check("a_turn2_oe", uio_oe, 0);
        tick(); #1;
        check("a_next_gnt", gnt, 4'b0001);
        check("a_next_last", last, 1);
        check("a_next_oe", uio_oe, 0);
        tick(); req = '0; #1;
        check("a_pad_out", uio_out, 8'hC3);
        check("a_pad_oe", uio_oe, 8'hAA);

        // Reset asserted mid-burst, then round-robin from requester 0
        tick(); set_lane(3, 4'd7, 8'h99, 8'hFF); req = 4'b1000; #1;
        tick(); #1;
        check("m_turn_gnt", gnt, 0);
        tick(); #1;
        check("m_b1_gnt", gnt, 4'b1000);
        tick(); #1;
        check("m_b2_oe", uio_oe, 8'hFF);
        check("m_b2_out", uio_out, 8'h99);
        rst = 1'b1; #1;
        check("m_rst_oe", uio_oe, 0);
        check("m_rst_gnt", gnt, 0);
        check("m_rst_busy", busy, 0);
        check("m_rst_out", uio_out, 0);
        tick(); rst = 1'b0;
        for (int k = 0; k < N; k++) set_lane(k, 4'd0, 8'h10 + 8'(k), 8'hFF);
        req = 4'b1111; #1;
        check("f_start_busy", busy, 0);
        for (int r = 0; r < 5; r++) begin
            int k;
            k = r % N;
            tick(); #1;
            check($sformatf("f%0d_turn_gnt", r), gnt, 0);
            check($sformatf("f%0d_turn_busy", r), busy, 1);
            check($sformatf("f%0d_turn_oe", r), uio_oe, 0);
            tick(); #1;
            check($sformatf("f%0d_own_gnt", r), gnt, 32'(1) << k);
            check($sformatf("f%0d_own_last", r), last, 1);
            check($sformatf("f%0d_own_oe", r), uio_oe, 0);
            tick(); #1;
            check($sformatf("f%0d_idle_gnt", r), gnt, 0);
            check($sformatf("f%0d_idle_oe", r), uio_oe, 8'hFF);
            check($sformatf("f%0d_idle_out", r), uio_out, 8'h10 + 8'(k));
        end
        req = '0;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
